// File: rtl/dmem_responder.sv
// dmem_responder: single-outstanding data-memory responder.
// A request is latched when accepted in IDLE. A good request waits LATENCY
// cycles and then gives a one-cycle response. A misaligned or out-of-range
// request gives an error pulse in the next cycle.
// Storage is a 64-bit word array with a registered read port.
module dmem_responder #(
   parameter int DEPTH_WORDS = 128,
   parameter int ADDR_W      = 64,
   parameter int LATENCY     = 2
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_write,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [63:0]       req_wdata,
   output logic              rsp_valid,
   output logic [63:0]       rsp_rdata,
   output logic              rsp_err,
   output logic              busy
);

   localparam int                IDX_W      = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
   // Compare at full address width so that set upper bits never wrap into range.
   localparam logic [ADDR_W-1:0] BYTE_LIMIT = ADDR_W'(8 * DEPTH_WORDS);
   localparam logic [3:0]        CNT_LOAD   = (LATENCY > 0) ? 4'(LATENCY - 1) : 4'd0;

   typedef enum logic [1:0] {
      S_IDLE,
      S_WAIT,
      S_RESP,
      S_ERR
   } state_t;

   state_t            state_q, state_d;
   logic [3:0]        cnt_q, cnt_d;
   logic [IDX_W-1:0]  idx_q, idx_d;
   logic [63:0]       wdata_q, wdata_d;
   logic              write_q, write_d;
   logic [63:0]       rd_data_q;
   logic              accept;
   logic              addr_bad;

   logic [63:0]       mem [DEPTH_WORDS];

   // Acceptance and address legality of the presented request.
   always_comb begin
      accept   = req_valid && (state_q == S_IDLE);
      addr_bad = (req_addr[2:0] != 3'd0) || (req_addr >= BYTE_LIMIT);
   end

   // Next-state logic: latch the request on acceptance, count wait cycles, return to IDLE after the response.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      idx_d   = idx_q;
      wdata_d = wdata_q;
      write_d = write_q;
      case (state_q)
         S_IDLE: begin
            if (accept) begin
               idx_d   = req_addr[IDX_W+2:3];
               wdata_d = req_wdata;
               write_d = req_write;
               if (addr_bad) begin
                  state_d = S_ERR;
               end else if (LATENCY == 0) begin
                  state_d = S_RESP;
               end else begin
                  state_d = S_WAIT;
                  cnt_d   = CNT_LOAD;
               end
            end
         end
         S_WAIT: begin
            if (cnt_q == 4'd0) begin
               state_d = S_RESP;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         S_RESP:  state_d = S_IDLE;
         S_ERR:   state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // State and latched-request registers; reset drops any in-flight request.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         cnt_q   <= 4'd0;
         idx_q   <= '0;
         wdata_q <= 64'd0;
         write_q <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         idx_q   <= idx_d;
         wdata_q <= wdata_d;
         write_q <= write_d;
      end
   end

   // Word storage: a store commits at the edge that ends RESP, unless reset is asserted on that edge.
   // The read address follows idx_d, so read data is ready when RESP begins, even with zero latency.
   always_ff @(posedge clk) begin
      if (rst_n && (state_q == S_RESP) && write_q) begin
         mem[idx_q] <= wdata_q;
      end
      rd_data_q <= mem[idx_d];
   end

   // Response outputs are decoded from the state register only.
   always_comb begin
      req_ready = (state_q == S_IDLE);
      busy      = (state_q != S_IDLE);
      rsp_valid = (state_q == S_RESP) || (state_q == S_ERR);
      rsp_err   = (state_q == S_ERR);
      rsp_rdata = ((state_q == S_RESP) && !write_q) ? rd_data_q : 64'd0;
   end

endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: scoreboard bench for a LATENCY=2 instance (directed and random)
// and a LATENCY=0 instance (back-to-back with req_valid held high).
module tb_dmem_responder;

   localparam int DEPTH = 128;

   typedef struct {
      logic        err;
      logic [63:0] rdata;
      int          cyc;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst_n;
   int          cyc = 0;
   int          n_total = 0;
   int          n_pass = 0;
   bit          mon_en = 1'b0;

   // LATENCY=2 instance signals
   logic        a_valid, a_ready, a_write, a_rsp_valid, a_rsp_err, a_busy;
   logic [63:0] a_addr, a_wdata, a_rdata;
   // LATENCY=0 instance signals
   logic        z_valid, z_ready, z_write, z_rsp_valid, z_rsp_err, z_busy;
   logic [63:0] z_addr, z_wdata, z_rdata;

   exp_t        q_a[$];
   exp_t        q_z[$];
   exp_t        e_a, e_z;
   logic        prev_a = 1'b0;
   logic        prev_z = 1'b0;
   logic [63:0] model [DEPTH];

   dmem_responder #(.DEPTH_WORDS(DEPTH), .ADDR_W(64), .LATENCY(2)) dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid(a_valid), .req_ready(a_ready), .req_write(a_write),
      .req_addr(a_addr), .req_wdata(a_wdata),
      .rsp_valid(a_rsp_valid), .rsp_rdata(a_rdata), .rsp_err(a_rsp_err), .busy(a_busy)
   );

   dmem_responder #(.DEPTH_WORDS(DEPTH), .ADDR_W(64), .LATENCY(0)) dut0 (
      .clk(clk), .rst_n(rst_n),
      .req_valid(z_valid), .req_ready(z_ready), .req_write(z_write),
      .req_addr(z_addr), .req_wdata(z_wdata),
      .rsp_valid(z_rsp_valid), .rsp_rdata(z_rdata), .rsp_err(z_rsp_err), .busy(z_busy)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
   endtask

   task automatic fail_now(input string name);
      n_total++;
      $display("FAIL %s: got no event expected event (cycle %0d)", name, cyc);
   endtask

   // Reference rules: legality, expected data and expected response cycle.
   function automatic exp_t predict(input logic w, input logic [63:0] addr, input logic [63:0] wd,
                                    input int acc, input int lat);
      exp_t e;
      e.err   = (addr % 8 != 0) || (addr >= 64'(8 * DEPTH));
      e.rdata = (e.err || w) ? 64'd0 : model[addr / 8];
      e.cyc   = e.err ? acc + 1 : acc + lat + 1;
      if (!e.err && w) model[addr / 8] = wd;
      return e;
   endfunction

   // Monitor for the LATENCY=2 instance: invariants plus scoreboard pop.
   always @(negedge clk) begin
      if (mon_en) begin
         check("a_busy_vs_ready", {63'd0, a_busy}, {63'd0, !a_ready});
         check("a_valid_run", {63'd0, a_rsp_valid && prev_a}, 64'd0);
         if (!a_rsp_valid) check("a_rdata_idle", a_rdata, 64'd0);
         if (a_rsp_valid) begin
            if (q_a.size() == 0) fail_now("a_unexpected_rsp");
            else begin
               e_a = q_a.pop_front();
               check("a_rsp_err", {63'd0, a_rsp_err}, {63'd0, e_a.err});
               check("a_rsp_rdata", a_rdata, e_a.rdata);
               check("a_rsp_cycle", 64'(cyc), 64'(e_a.cyc));
               $display("a rsp cyc=%0d err=%0d rdata=0x%0h", cyc, a_rsp_err, a_rdata);
            end
         end
         prev_a <= a_rsp_valid;
      end
   end

   // Monitor for the LATENCY=0 instance.
   always @(negedge clk) begin
      if (mon_en) begin
         check("z_busy_vs_ready", {63'd0, z_busy}, {63'd0, !z_ready});
         check("z_valid_run", {63'd0, z_rsp_valid && prev_z}, 64'd0);
         if (!z_rsp_valid) check("z_rdata_idle", z_rdata, 64'd0);
         if (z_rsp_valid) begin
            if (q_z.size() == 0) fail_now("z_unexpected_rsp");
            else begin
               e_z = q_z.pop_front();
               check("z_rsp_err", {63'd0, z_rsp_err}, {63'd0, e_z.err});
               check("z_rsp_rdata", z_rdata, e_z.rdata);
               check("z_rsp_cycle", 64'(cyc), 64'(e_z.cyc));
               $display("z rsp cyc=%0d err=%0d rdata=0x%0h", cyc, z_rsp_err, z_rdata);
            end
         end
         prev_z <= z_rsp_valid;
      end
   end

   // Issue one request on the LATENCY=2 instance; called and returns at a negedge.
   // Returns one cycle after acceptance with inputs scrambled to prove they are latched.
   task automatic issue_a(input logic w, input logic [63:0] addr, input logic [63:0] wd,
                          input bit track, output int acc);
      int n;
      a_valid = 1'b1;
      a_write = w;
      a_addr  = addr;
      a_wdata = wd;
      n = 0;
      while (!a_ready) begin
         if (n >= 40) begin
            fail_now("a_accept_timeout");
            break;
         end
         @(negedge clk);
         n++;
      end
      acc = cyc;
      if (track) q_a.push_back(predict(w, addr, wd, acc, 2));
      $display("a req cyc=%0d write=%0d addr=0x%0h wdata=0x%0h", acc, w, addr, wd);
      @(negedge clk);
      a_valid = 1'b0;
      a_write = 1'($urandom);
      a_addr  = {$urandom, $urandom};
      a_wdata = {$urandom, $urandom};
   endtask

   task automatic drain(input string name);
      int n;
      n = 0;
      while ((q_a.size() != 0 || q_z.size() != 0) && n < 60) begin
         @(negedge clk);
         n++;
      end
      if (q_a.size() != 0 || q_z.size() != 0) fail_now(name);
   endtask

   initial begin
      int          acc, st_acc, kind, n;
      logic [63:0] addr, last_addr, wd;
      logic        w;
      exp_t        e;

      rst_n   = 1'b0;
      a_valid = 1'b0; a_write = 1'b0; a_addr = 64'd0; a_wdata = 64'd0;
      z_valid = 1'b0; z_write = 1'b0; z_addr = 64'd0; z_wdata = 64'd0;
      for (int i = 0; i < DEPTH; i++) model[i] = 64'd0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      // Reset state of both instances
      check("rst_a_ready", {63'd0, a_ready}, 64'd1);
      check("rst_a_busy", {63'd0, a_busy}, 64'd0);
      check("rst_a_valid", {63'd0, a_rsp_valid}, 64'd0);
      check("rst_a_err", {63'd0, a_rsp_err}, 64'd0);
      check("rst_a_rdata", a_rdata, 64'd0);
      check("rst_z_ready", {63'd0, z_ready}, 64'd1);
      check("rst_z_valid", {63'd0, z_rsp_valid}, 64'd0);
      mon_en = 1'b1;

      // Known contents for every word
      for (int i = 0; i < DEPTH; i++) begin
         issue_a(1'b1, 64'(i * 8), {$urandom, $urandom}, 1'b1, acc);
      end

      // Store then load 0x10; bad load 0x13; edges of the address range
      issue_a(1'b1, 64'h10, 64'hDEADBEEF, 1'b1, acc);
      issue_a(1'b0, 64'h10, 64'd0, 1'b1, acc);
      issue_a(1'b0, 64'h13, 64'd0, 1'b1, acc);
      issue_a(1'b0, 64'h10, 64'd0, 1'b1, acc);
      issue_a(1'b0, 64'h3F8, 64'd0, 1'b1, acc);
      issue_a(1'b1, 64'h400, 64'h1111_2222_3333_4444, 1'b1, acc);
      issue_a(1'b1, 64'h8000_0000_0000_0000, 64'h5555, 1'b1, acc);
      issue_a(1'b1, 64'h1_0000_0008, 64'h6666, 1'b1, acc);
      issue_a(1'b0, 64'h0, 64'd0, 1'b1, acc);
      issue_a(1'b0, 64'h8, 64'd0, 1'b1, acc);
      drain("a_drain_directed");

      // Reset during WAIT drops the store to 0x20
      issue_a(1'b1, 64'h20, 64'd0, 1'b1, acc);
      issue_a(1'b1, 64'h20, 64'd5, 1'b0, acc);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      check("post_rst_ready", {63'd0, a_ready}, 64'd1);
      issue_a(1'b0, 64'h20, 64'd0, 1'b1, acc);
      drain("a_drain_reset");

      // LATENCY=0: store 0x8 then load 0x8 with req_valid held high
      z_valid = 1'b1; z_write = 1'b1; z_addr = 64'h8; z_wdata = 64'hCAFE_F00D_1234_5678;
      n = 0;
      while (!z_ready && n < 40) begin @(negedge clk); n++; end
      if (!z_ready) fail_now("z_accept_timeout");
      st_acc = cyc;
      e.err = 1'b0; e.rdata = 64'd0; e.cyc = st_acc + 1;
      q_z.push_back(e);
      $display("z req cyc=%0d write=1 addr=0x8 wdata=0x%0h", st_acc, z_wdata);
      @(negedge clk);
      z_write = 1'b0; z_wdata = 64'd0;
      n = 0;
      while (!z_ready && n < 40) begin @(negedge clk); n++; end
      if (!z_ready) fail_now("z_accept_timeout");
      e.err = 1'b0; e.rdata = 64'hCAFE_F00D_1234_5678; e.cyc = st_acc + 3;
      q_z.push_back(e);
      $display("z req cyc=%0d write=0 addr=0x8", cyc);
      @(negedge clk);
      z_valid = 1'b0;
      drain("z_drain");

      // Randomized mix of legal, boundary and illegal requests
      last_addr = 64'h0;
      for (int i = 0; i < 200; i++) begin
         kind = $urandom_range(0, 9);
         w    = 1'($urandom);
         wd   = {$urandom, $urandom};
         case (kind)
            0:       addr = 64'($urandom_range(0, 8 * DEPTH - 1)) | 64'd1;
            1:       addr = 64'(8 * DEPTH - 8);
            2:       addr = 64'(8 * DEPTH);
            3:       addr = (64'd1 << $urandom_range(10, 63)) | 64'($urandom_range(0, DEPTH - 1) * 8);
            9:       begin addr = last_addr; w = 1'b0; end
            default: addr = 64'($urandom_range(0, DEPTH - 1) * 8);
         endcase
         issue_a(w, addr, wd, 1'b1, acc);
         last_addr = addr;
         repeat ($urandom_range(0, 2)) @(negedge clk);
      end
      drain("a_drain_random");

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
